// File: rtl/issue_stage.sv
// issue_stage: register file read, RAW hazard scoreboard and the registered stage-4 bundle.
// When FWD_EN is set, the stage-6 writeback is bypassed into operand read.
module issue_stage #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter bit FWD_EN = 1'b1
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            valid3,
    input  logic [4:0]      rs1_3,
    input  logic [4:0]      rs2_3,
    input  logic [4:0]      rd3,
    input  logic            use_rs1_3,
    input  logic            use_rs2_3,
    input  logic            use_imm3,
    input  logic [XLEN-1:0] I_imm3,
    input  logic [XLEN-1:0] B_imm3,
    input  logic [XLEN-1:0] J_imm3,
    input  logic [XLEN-1:0] U_imm3,
    input  logic [XLEN-1:0] S_imm3,
    input  logic [XLEN-1:0] pc3,
    input  logic            we3,
    input  logic            bneq3,
    input  logic            btype3,
    input  logic            j3,
    input  logic            jr3,
    input  logic            LUI3,
    input  logic            auipc3,
    input  logic [2:0]      fn3,
    input  logic [3:0]      alu_fn3,
    input  logic [3:0]      mem_op3,
    input  logic [2:0]      m_op3,
    input  logic [1:0]      pcselect3,
    input  logic            flush,
    input  logic            we6,
    input  logic [4:0]      rd6,
    input  logic [XLEN-1:0] wb_data6,
    output logic            stall,
    output logic [XLEN-1:0] op_a,
    output logic [XLEN-1:0] op_b,
    output logic [4:0]      rd4,
    output logic            we4,
    output logic [2:0]      fn4,
    output logic [3:0]      alu_fn4,
    output logic            bneq4,
    output logic            btype4,
    output logic            j4,
    output logic            jr4,
    output logic            LUI4,
    output logic            auipc4,
    output logic [3:0]      mem_op4,
    output logic [2:0]      m_op4,
    output logic [1:0]      pcselect4,
    output logic [XLEN-1:0] pc4,
    output logic [XLEN-1:0] B_imm4,
    output logic [XLEN-1:0] J_imm4,
    output logic [XLEN-1:0] U_imm4,
    output logic [XLEN-1:0] S_imm4
);
    typedef struct packed {
        logic [XLEN-1:0] op_a, op_b, pc, b_imm, j_imm, u_imm, s_imm;
        logic [4:0]      rd;
        logic            we;
        logic [2:0]      fn;
        logic [3:0]      alu_fn;
        logic            bneq, btype, j, jr, lui, auipc;
        logic [3:0]      mem_op;
        logic [2:0]      m_op;
        logic [1:0]      pcselect;
    } s4_t;

    logic [XLEN-1:0] rf_q [NREGS];
    s4_t             s4_q, s4_d;
    logic [4:0]      rd5s_q;
    logic            we5s_q;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic            hit4, hit5, hit6, load;

    function automatic logic hit(input logic use_rs, input logic [4:0] rs,
                                 input logic [4:0] rd, input logic we);
        return use_rs && rs != 5'd0 && we && rd == rs;
    endfunction

    assign rs1_val = rs1_3 == 5'd0 ? '0 : (FWD_EN && we6 && rd6 == rs1_3) ? wb_data6 : rf_q[rs1_3];
    assign rs2_val = rs2_3 == 5'd0 ? '0 : (FWD_EN && we6 && rd6 == rs2_3) ? wb_data6 : rf_q[rs2_3];

    assign hit4 = hit(use_rs1_3, rs1_3, s4_q.rd, s4_q.we) || hit(use_rs2_3, rs2_3, s4_q.rd, s4_q.we);
    assign hit5 = hit(use_rs1_3, rs1_3, rd5s_q, we5s_q) || hit(use_rs2_3, rs2_3, rd5s_q, we5s_q);
    assign hit6 = hit(use_rs1_3, rs1_3, rd6, we6) || hit(use_rs2_3, rs2_3, rd6, we6);
    // Without the bypass the value only becomes readable once the register file holds it.
    assign stall = nrst && valid3 && !flush && (hit4 || hit5 || (!FWD_EN && hit6));
    assign load  = valid3 && !flush && !stall;

    always_comb begin
        s4_d = '0;
        if (load) begin
            s4_d.op_a     = rs1_val;
            s4_d.op_b     = use_imm3 ? I_imm3 : rs2_val;
            s4_d.pc       = pc3;
            s4_d.b_imm    = B_imm3;
            s4_d.j_imm    = J_imm3;
            s4_d.u_imm    = U_imm3;
            s4_d.s_imm    = S_imm3;
            s4_d.rd       = rd3;
            s4_d.we       = we3;
            s4_d.fn       = fn3;
            s4_d.alu_fn   = alu_fn3;
            s4_d.bneq     = bneq3;
            s4_d.btype    = btype3;
            s4_d.j        = j3;
            s4_d.jr       = jr3;
            s4_d.lui      = LUI3;
            s4_d.auipc    = auipc3;
            s4_d.mem_op   = mem_op3;
            s4_d.m_op     = m_op3;
            s4_d.pcselect = pcselect3;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            s4_q   <= '0;
            rd5s_q <= '0;
            we5s_q <= 1'b0;
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else begin
            s4_q   <= s4_d;
            rd5s_q <= s4_q.rd;
            we5s_q <= s4_q.we;
            if (we6 && rd6 != 5'd0) rf_q[rd6] <= wb_data6;
        end
    end

    assign op_a      = s4_q.op_a;
    assign op_b      = s4_q.op_b;
    assign rd4       = s4_q.rd;
    assign we4       = s4_q.we;
    assign fn4       = s4_q.fn;
    assign alu_fn4   = s4_q.alu_fn;
    assign bneq4     = s4_q.bneq;
    assign btype4    = s4_q.btype;
    assign j4        = s4_q.j;
    assign jr4       = s4_q.jr;
    assign LUI4      = s4_q.lui;
    assign auipc4    = s4_q.auipc;
    assign mem_op4   = s4_q.mem_op;
    assign m_op4     = s4_q.m_op;
    assign pcselect4 = s4_q.pcselect;
    assign pc4       = s4_q.pc;
    assign B_imm4    = s4_q.b_imm;
    assign J_imm4    = s4_q.j_imm;
    assign U_imm4    = s4_q.u_imm;
    assign S_imm4    = s4_q.s_imm;
endmodule

// File: tb/tb_issue_stage.sv
// tb_issue_stage: drives a forwarding (index 0) and a non-forwarding (index 1) issue_stage
// with the same inputs and checks both against a pipeline-occupancy reference model.
module tb_issue_stage;
    logic clk, nrst;
    logic valid3, use_rs1_3, use_rs2_3, use_imm3, we3, bneq3, btype3, j3, jr3, LUI3, auipc3;
    logic flush, we6;
    logic [4:0] rs1_3, rs2_3, rd3, rd6;
    logic [31:0] I_imm3, B_imm3, J_imm3, U_imm3, S_imm3, pc3, wb_data6;
    logic [2:0] fn3, m_op3;
    logic [3:0] alu_fn3, mem_op3;
    logic [1:0] pcselect3;

    logic [1:0] stall_w, we4_w, bneq4_w, btype4_w, j4_w, jr4_w, lui4_w, auipc4_w;
    logic [1:0][31:0] op_a_w, op_b_w, pc4_w, bi_w, ji_w, ui_w, si_w;
    logic [1:0][4:0] rd4_w;
    logic [1:0][2:0] fn4_w, m_op4_w;
    logic [1:0][3:0] alu_fn4_w, mem_op4_w;
    logic [1:0][1:0] pcsel4_w;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        issue_stage #(.XLEN(32), .NREGS(32), .FWD_EN(g == 0)) dut (
            .clk(clk), .nrst(nrst), .valid3(valid3), .rs1_3(rs1_3), .rs2_3(rs2_3), .rd3(rd3),
            .use_rs1_3(use_rs1_3), .use_rs2_3(use_rs2_3), .use_imm3(use_imm3),
            .I_imm3(I_imm3), .B_imm3(B_imm3), .J_imm3(J_imm3), .U_imm3(U_imm3), .S_imm3(S_imm3),
            .pc3(pc3), .we3(we3), .bneq3(bneq3), .btype3(btype3), .j3(j3), .jr3(jr3),
            .LUI3(LUI3), .auipc3(auipc3), .fn3(fn3), .alu_fn3(alu_fn3), .mem_op3(mem_op3),
            .m_op3(m_op3), .pcselect3(pcselect3), .flush(flush), .we6(we6), .rd6(rd6),
            .wb_data6(wb_data6), .stall(stall_w[g]), .op_a(op_a_w[g]), .op_b(op_b_w[g]),
            .rd4(rd4_w[g]), .we4(we4_w[g]), .fn4(fn4_w[g]), .alu_fn4(alu_fn4_w[g]),
            .bneq4(bneq4_w[g]), .btype4(btype4_w[g]), .j4(j4_w[g]), .jr4(jr4_w[g]),
            .LUI4(lui4_w[g]), .auipc4(auipc4_w[g]), .mem_op4(mem_op4_w[g]), .m_op4(m_op4_w[g]),
            .pcselect4(pcsel4_w[g]), .pc4(pc4_w[g]), .B_imm4(bi_w[g]), .J_imm4(ji_w[g]),
            .U_imm4(ui_w[g]), .S_imm4(si_w[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]  op_a, op_b;
        logic [4:0]   rd;
        logic         we;
        logic [21:0]  ctrl;
        logic [159:0] pass;
    } m4_t;

    m4_t         m4 [2];
    logic [4:0]  m5rd [2];
    logic        m5we [2];
    logic [31:0] mregs [32];
    int          errs = 0, checks = 0;
    int          sc [2];

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic hit(logic u, logic [4:0] rs, logic [4:0] rd, logic we);
        return u && rs != 0 && we && rd == rs;
    endfunction

    function automatic logic hit_any(logic [4:0] rd, logic we);
        return hit(use_rs1_3, rs1_3, rd, we) || hit(use_rs2_3, rs2_3, rd, we);
    endfunction

    function automatic logic m_stall(int i);
        if (!nrst || !valid3 || flush) return 1'b0;
        return hit_any(m4[i].rd, m4[i].we) || hit_any(m5rd[i], m5we[i]) || (i == 1 && hit_any(rd6, we6));
    endfunction

    function automatic logic [31:0] m_read(int i, logic [4:0] rs);
        if (rs == 0) return 32'd0;
        if (i == 0 && we6 && rd6 == rs) return wb_data6;
        return mregs[rs];
    endfunction

    function automatic m4_t m_next(int i);
        m4_t n = '0;
        if (valid3 && !flush && !m_stall(i)) begin
            n.op_a = m_read(i, rs1_3);
            n.op_b = use_imm3 ? I_imm3 : m_read(i, rs2_3);
            n.rd   = rd3;
            n.we   = we3;
            n.ctrl = {fn3, alu_fn3, bneq3, btype3, j3, jr3, LUI3, auipc3, mem_op3, m_op3, pcselect3};
            n.pass = {pc3, B_imm3, J_imm3, U_imm3, S_imm3};
        end
        return n;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            m4[i] = '0;
            m5rd[i] = '0;
            m5we[i] = 1'b0;
        end
        for (int r = 0; r < 32; r++) mregs[r] = '0;
    endtask

    task automatic check_out();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("op_a[%0d]", i), op_a_w[i], m4[i].op_a);
            chk($sformatf("op_b[%0d]", i), op_b_w[i], m4[i].op_b);
            chk($sformatf("rd_we4[%0d]", i), {rd4_w[i], we4_w[i]}, {m4[i].rd, m4[i].we});
            chk($sformatf("ctrl4[%0d]", i), {fn4_w[i], alu_fn4_w[i], bneq4_w[i], btype4_w[i], j4_w[i],
                jr4_w[i], lui4_w[i], auipc4_w[i], mem_op4_w[i], m_op4_w[i], pcsel4_w[i]}, m4[i].ctrl);
            chk($sformatf("pass4[%0d]", i), {pc4_w[i], bi_w[i], ji_w[i], ui_w[i], si_w[i]}, m4[i].pass);
        end
    endtask

    // One clock: check the combinational stall, advance the model at the edge, check stage 4.
    task automatic step();
        m4_t nx [2];
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("stall[%0d]", i), stall_w[i], m_stall(i));
            sc[i] += int'(stall_w[i]);
            nx[i] = m_next(i);
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            m5rd[i] = m4[i].rd;
            m5we[i] = m4[i].we;
            m4[i] = nx[i];
        end
        if (we6 && rd6 != 0) mregs[rd6] = wb_data6;
        #1;
        check_out();
        @(negedge clk);
    endtask

    task automatic clr();
        {valid3, use_rs1_3, use_rs2_3, use_imm3, we3, bneq3, btype3, j3, jr3, LUI3, auipc3, flush, we6} = '0;
        {rs1_3, rs2_3, rd3, rd6} = '0;
        {I_imm3, B_imm3, J_imm3, U_imm3, S_imm3, pc3, wb_data6} = '0;
        {fn3, m_op3, alu_fn3, mem_op3, pcselect3} = '0;
    endtask

    initial begin
        clr();
        nrst = 1'b0;
        m_reset();
        #2;
        check_out();
        chk("reset_stall", stall_w, 2'b00);
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;
        step();
        step();

        // write x5 then read it with an immediate operand
        we6 = 1'b1; rd6 = 5'd5; wb_data6 = 32'h1234;
        step();
        clr();
        valid3 = 1'b1; rs1_3 = 5'd5; use_rs1_3 = 1'b1; use_imm3 = 1'b1; I_imm3 = 32'd4;
        rd3 = 5'd6; we3 = 1'b1; pc3 = 32'h10;
        step();
        for (int i = 0; i < 2; i++) begin
            chk("addi_op_a", op_a_w[i], 32'h1234);
            chk("addi_op_b", op_b_w[i], 32'd4);
        end

        // back-to-back dependency on x3
        clr();
        valid3 = 1'b1; rd3 = 5'd3; we3 = 1'b1; alu_fn3 = 4'h1;
        step();
        clr();
        valid3 = 1'b1; rd3 = 5'd4; we3 = 1'b1; rs1_3 = 5'd3; use_rs1_3 = 1'b1; alu_fn3 = 4'h8;
        sc = '{0, 0};
        step();
        step();
        we6 = 1'b1; rd6 = 5'd3; wb_data6 = 32'hDEAD;
        step();
        chk("fwd_op_a", op_a_w[0], 32'hDEAD);
        we6 = 1'b0;
        step();
        chk("nofwd_op_a", op_a_w[1], 32'hDEAD);
        chk("fwd_stall_cycles", sc[0], 2);
        chk("nofwd_stall_cycles", sc[1], 3);

        // producer writing x0 never blocks a reader of x0
        clr();
        valid3 = 1'b1; rd3 = 5'd0; we3 = 1'b1;
        step();
        clr();
        valid3 = 1'b1; use_rs1_3 = 1'b1; use_rs2_3 = 1'b1; rd3 = 5'd8;
        sc = '{0, 0};
        step();
        chk("x0_stall", sc[0] + sc[1], 0);
        for (int i = 0; i < 2; i++) chk("x0_op_a", op_a_w[i], 32'd0);

        // store depending on a producer already in stage 5
        clr();
        valid3 = 1'b1; rd3 = 5'd7; we3 = 1'b1;
        step();
        clr();
        step();
        valid3 = 1'b1; rs2_3 = 5'd7; use_rs2_3 = 1'b1; S_imm3 = 32'h40; mem_op3 = 4'h2;
        sc = '{0, 0};
        step();
        we6 = 1'b1; rd6 = 5'd7; wb_data6 = 32'h7777;
        step();
        chk("store_fwd_op_b", op_b_w[0], 32'h7777);
        chk("store_fwd_s_imm", si_w[0], 32'h40);
        we6 = 1'b0;
        step();
        chk("store_nofwd_op_b", op_b_w[1], 32'h7777);
        chk("store_fwd_stalls", sc[0], 1);
        chk("store_nofwd_stalls", sc[1], 2);

        // flush beats a hazard and drops the decode instruction
        clr();
        valid3 = 1'b1; rd3 = 5'd9; we3 = 1'b1;
        step();
        clr();
        valid3 = 1'b1; rs1_3 = 5'd9; use_rs1_3 = 1'b1; flush = 1'b1; mem_op3 = 4'h3; j3 = 1'b1; we3 = 1'b1;
        #1;
        chk("flush_stall", stall_w, 2'b00);
        step();
        for (int i = 0; i < 2; i++) chk("flush_bubble", {we4_w[i], mem_op4_w[i], j4_w[i]}, 6'd0);
        clr();
        step();

        // reset asserted while stalling
        valid3 = 1'b1; rd3 = 5'd10; we3 = 1'b1;
        step();
        clr();
        valid3 = 1'b1; rs1_3 = 5'd10; use_rs1_3 = 1'b1;
        step();
        nrst = 1'b0;
        #1;
        m_reset();
        check_out();
        chk("midreset_stall", stall_w, 2'b00);
        @(negedge clk);
        nrst = 1'b1;
        clr();
        valid3 = 1'b1; rs1_3 = 5'd5; use_rs1_3 = 1'b1;
        step();
        for (int i = 0; i < 2; i++) chk("cleared_x5", op_a_w[i], 32'd0);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            valid3 = $urandom_range(0, 3) != 0;
            flush = $urandom_range(0, 7) == 0;
            rs1_3 = 5'($urandom_range(0, 7));
            rs2_3 = 5'($urandom_range(0, 7));
            rd3 = 5'($urandom_range(0, 7));
            use_rs1_3 = 1'($urandom);
            use_rs2_3 = 1'($urandom);
            use_imm3 = 1'($urandom);
            {we3, bneq3, btype3, j3, jr3, LUI3, auipc3} = 7'($urandom);
            {fn3, alu_fn3, mem_op3, m_op3, pcselect3} = 16'($urandom);
            I_imm3 = $urandom; B_imm3 = $urandom; J_imm3 = $urandom;
            U_imm3 = $urandom; S_imm3 = $urandom; pc3 = $urandom;
            we6 = 1'($urandom);
            rd6 = 5'($urandom_range(0, 7));
            wb_data6 = $urandom;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
